rev_alu_out_stage: RTL

- Output stage directly downstream of the modified Toffoli datapath in the reversible-logic ALU.
- Consumes the P/Q/R buses and selects the ALU result per operation. Also computes the status flags.
- Buffers results in a small FIFO with a valid/ready handshake, so a stalled consumer never corrupts in-flight results.
- Keeps a running count of delivered results.

---
 rtl/rev_alu_out_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rev_alu_out_stage.sv
`default_nettype none
// ============================================================================
//  Module      : rev_alu_out_stage
//  Description : Output stage of the reversible-logic ALU. Selects the result
//                from the Toffoli P/Q/R buses, computes zero/parity/negative
//                flags at write time, and buffers result+tag+flags in a small
//                FIFO with a valid/ready handshake. Counts delivered results.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, rst            : clock (rising edge), asynchronous active-high reset
//    in_valid/in_ready   : upstream handshake (in_ready is registered-state only)
//    in_sel              : 00=P 01=Q 10=R 11=P^Q^R
//    in_tag              : tag carried with the result
//    p, q, r             : Toffoli datapath outputs
//    out_valid/out_ready : downstream handshake
//    out_data/out_tag    : head-of-FIFO result and tag
//    out_zero/parity/neg : stored flags of the head result
//    result_count        : completed output handshakes, wraps mod 2^16
//    stall_count         : edges with out_valid && !out_ready, saturating;
//                          present only when REV_OUT_STALL_CNT_EN is defined,
//                          otherwise tied to zero
// ============================================================================
module rev_alu_out_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_sel,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [WIDTH-1:0]   p,
    input  logic [WIDTH-1:0]   q,
    input  logic [WIDTH-1:0]   r,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero,
    output logic               out_parity,
    output logic               out_neg,
    output logic [15:0]        result_count,
    output logic [15:0]        stall_count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = DEPTH[c_PTR_W:0];

    // FIFO storage: result, tag and the flags captured at write time
    logic [WIDTH-1:0]   r_data   [DEPTH];
    logic [TAG_W-1:0]   r_tag    [DEPTH];
    logic               r_zero   [DEPTH];
    logic               r_parity [DEPTH];
    logic               r_neg    [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [15:0]        r_result_count;

    logic [WIDTH-1:0]   w_sel_data;
    logic               w_sel_zero;
    logic               w_sel_parity;
    logic               w_sel_neg;
    logic               w_push;
    logic               w_pop;

    // ------------------------------------------------------------------
    // Result select and flag generation
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_data = p;
        case (in_sel)
            2'b00:   w_sel_data = p;
            2'b01:   w_sel_data = q;
            2'b10:   w_sel_data = r;
            default: w_sel_data = p ^ q ^ r;
        endcase
    end

    assign w_sel_zero   = (w_sel_data == '0);
    assign w_sel_parity = ^w_sel_data;
    assign w_sel_neg    = w_sel_data[WIDTH-1];

    // ------------------------------------------------------------------
    // Handshake. Both ready/valid depend only on the occupancy register,
    // so out_ready never reaches in_ready combinationally. An empty FIFO
    // has out_valid=0, so a push into it cannot be popped on the same edge.
    // ------------------------------------------------------------------
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i]   <= '0;
                r_tag[i]    <= '0;
                r_zero[i]   <= 1'b0;
                r_parity[i] <= 1'b0;
                r_neg[i]    <= 1'b0;
            end
        end else if (w_push) begin
            r_data[r_wr_ptr]   <= w_sel_data;
            r_tag[r_wr_ptr]    <= in_tag;
            r_zero[r_wr_ptr]   <= w_sel_zero;
            r_parity[r_wr_ptr] <= w_sel_parity;
            r_neg[r_wr_ptr]    <= w_sel_neg;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and delivered-result counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_result_count <= 16'h0000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr       <= r_rd_ptr + 1'b1;
                r_result_count <= r_result_count + 16'h0001;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_data     = r_data[r_rd_ptr];
    assign out_tag      = r_tag[r_rd_ptr];
    assign out_zero     = r_zero[r_rd_ptr];
    assign out_parity   = r_parity[r_rd_ptr];
    assign out_neg      = r_neg[r_rd_ptr];
    assign result_count = r_result_count;

    // ------------------------------------------------------------------
    // Optional stall counter (saturating)
    // ------------------------------------------------------------------
`ifdef REV_OUT_STALL_CNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= 16'h0000;
        end else if (out_valid && !out_ready && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'h0001;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = 16'h0000;
`endif

endmodule
`default_nettype wire
